// File: rtl/optical_frame_tx.sv
// Optical frame transmitter: serialises one byte per frame as
// alternating preamble, start bit, 8 data bits MSB first, even parity, stop bit.
module optical_frame_tx #(
    parameter int unsigned BIT_CYCLES    = 12,
    parameter int unsigned PREAMBLE_BITS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx_out,
    output logic       busy,
    output logic       bit_tick,
    output logic       frame_done
);

    localparam int unsigned CYC_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned BIT_W = $clog2((PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8);
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PREAMBLE_BITS - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(7);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state, state_nx;
    logic [CYC_W-1:0] cyc_cnt, cyc_nx;
    logic [BIT_W-1:0] bit_cnt, bit_nx;
    logic [7:0]       shreg, shreg_nx;
    logic             tx_nx, busy_nx, tick_nx, done_nx, ready_nx;
    logic             last_cyc;

    // State, counters, byte register and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            tx_out     <= 1'b0;
            busy       <= 1'b0;
            bit_tick   <= 1'b0;
            frame_done <= 1'b0;
            data_ready <= 1'b0;
        end else begin
            state      <= state_nx;
            cyc_cnt    <= cyc_nx;
            bit_cnt    <= bit_nx;
            shreg      <= shreg_nx;
            tx_out     <= tx_nx;
            busy       <= busy_nx;
            bit_tick   <= tick_nx;
            frame_done <= done_nx;
            data_ready <= ready_nx;
        end
    end

    // Next state and next output values; the data byte rotates so it is
    // intact again for the parity bit after eight data bits
    always_comb begin
        state_nx = state;
        cyc_nx   = cyc_cnt;
        bit_nx   = bit_cnt;
        shreg_nx = shreg;
        last_cyc = (cyc_cnt == CYC_LAST);

        if (state == IDLE) begin
            if (data_valid && data_ready) begin
                state_nx = PREAMBLE;
                cyc_nx   = '0;
                bit_nx   = '0;
                shreg_nx = data_in;
            end
        end else begin
            cyc_nx = last_cyc ? '0 : cyc_cnt + 1'b1;
            if (last_cyc) begin
                case (state)
                    PREAMBLE: begin
                        if (bit_cnt == PRE_LAST) begin
                            state_nx = START;
                            bit_nx   = '0;
                        end else begin
                            bit_nx = bit_cnt + 1'b1;
                        end
                    end
                    START: begin
                        state_nx = DATA;
                        bit_nx   = '0;
                    end
                    DATA: begin
                        shreg_nx = {shreg[6:0], shreg[7]};
                        if (bit_cnt == DATA_LAST) begin
                            state_nx = PARITY;
                            bit_nx   = '0;
                        end else begin
                            bit_nx = bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        state_nx = STOP;
                        bit_nx   = '0;
                    end
                    STOP: begin
                        state_nx = IDLE;
                        bit_nx   = '0;
                    end
                    default: begin
                        state_nx = IDLE;
                        bit_nx   = '0;
                    end
                endcase
            end
        end

        case (state_nx)
            PREAMBLE: tx_nx = ~bit_nx[0];
            START:    tx_nx = 1'b1;
            DATA:     tx_nx = shreg_nx[7];
            PARITY:   tx_nx = ^shreg_nx;
            default:  tx_nx = 1'b0;
        endcase

        busy_nx  = (state_nx != IDLE);
        ready_nx = (state_nx == IDLE);
        tick_nx  = (state_nx != IDLE) && (cyc_nx == '0);
        done_nx  = (state_nx == STOP) && (cyc_nx == CYC_LAST);
    end

endmodule

// File: tb/tb_optical_frame_tx.sv
// Bench for optical_frame_tx: default instance plus a BIT_CYCLES=2,
// PREAMBLE_BITS=2 instance, checked every cycle against a frame-position model.
module tb_optical_frame_tx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dv    = 2'b00;
    logic [7:0] di0   = 8'h00;
    logic [7:0] di1   = 8'h00;
    logic [1:0] rdy, tx, bsy, tk, dn;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    optical_frame_tx u0 (
        .clock(clock), .reset(reset), .data_in(di0), .data_valid(dv[0]),
        .data_ready(rdy[0]), .tx_out(tx[0]), .busy(bsy[0]),
        .bit_tick(tk[0]), .frame_done(dn[0])
    );

    optical_frame_tx #(.BIT_CYCLES(2), .PREAMBLE_BITS(2)) u1 (
        .clock(clock), .reset(reset), .data_in(di1), .data_valid(dv[1]),
        .data_ready(rdy[1]), .tx_out(tx[1]), .busy(bsy[1]),
        .bit_tick(tk[1]), .frame_done(dn[1])
    );

    // ---------------- behavioural model ----------------
    int          m_pos   [2] = '{-1, -1};
    logic        m_ready [2] = '{1'b0, 1'b0};
    logic [31:0] m_frame [2] = '{32'd0, 32'd0};

    function automatic int bc_of(input int i);
        return (i == 0) ? 12 : 2;
    endfunction

    function automatic int pb_of(input int i);
        return (i == 0) ? 8 : 2;
    endfunction

    // frame bit k of the transmitted frame is returned in bit k
    function automatic logic [31:0] build(input logic [7:0] b, input int pb);
        logic [31:0] f;
        f = '0;
        for (int k = 0; k < pb; k++) f[k] = (k % 2 == 0);
        f[pb] = 1'b1;
        for (int j = 0; j < 8; j++) f[pb + 1 + j] = b[7 - j];
        f[pb + 9]  = ^b;
        f[pb + 10] = 1'b0;
        return f;
    endfunction

    function automatic logic [4:0] expect_out(input int i);
        int p;
        int bc;
        p  = m_pos[i];
        bc = bc_of(i);
        if (p < 0) return {m_ready[i], 4'b0000};
        return {1'b0, m_frame[i][p / bc], 1'b1, (p % bc == 0),
                (p == (pb_of(i) + 11) * bc - 1)};
    endfunction

    // Model advance on each active edge
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_pos[i]   = -1;
                m_ready[i] = 1'b0;
            end else begin
                if (m_pos[i] >= 0) begin
                    m_pos[i]++;
                    if (m_pos[i] == (pb_of(i) + 11) * bc_of(i)) m_pos[i] = -1;
                end else if (dv[i] && m_ready[i]) begin
                    m_pos[i]   = 0;
                    m_frame[i] = build((i == 0) ? di0 : di1, pb_of(i));
                end
                m_ready[i] = (m_pos[i] < 0);
            end
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            logic [4:0] a;
            logic [4:0] e;
            a = {rdy[i], tx[i], bsy[i], tk[i], dn[i]};
            e = expect_out(i);
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL model_u%0d t=%0t {ready,tx,busy,tick,done} got %b expected %b",
                         i, $time, a, e);
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic [7:0] b);
        if (i == 0) begin
            dv[0] = v;
            di0   = b;
        end else begin
            dv[1] = v;
            di1   = b;
        end
    endtask

    task automatic wait_ready(input int i);
        int n;
        n = 0;
        while (rdy[i] !== 1'b1 && n < 600) begin
            @(negedge clock);
            n++;
        end
        check("wait_ready_timeout", 32'(rdy[i] === 1'b1), 32'd1);
    endtask

    // Send one byte and check every line cycle against a hand-written bit literal
    // (first transmitted bit is the literal's MSB)
    task automatic run_frame(input int i, input logic [7:0] b, input logic [31:0] lit,
                             input bit noise);
        int bc;
        int nb;
        int len;
        int ticks;
        int dones;
        int done_at;
        bc = bc_of(i);
        nb = pb_of(i) + 11;
        len = bc * nb;
        ticks = 0;
        dones = 0;
        done_at = 0;
        wait_ready(i);
        drive(i, 1'b1, b);
        @(negedge clock);
        drive(i, 1'b0, b);
        for (int c = 1; c <= len; c++) begin
            check("tx_bit", 32'(tx[i]), 32'(lit[nb - 1 - (c - 1) / bc]));
            check("tick_align", 32'(tk[i]), 32'((c - 1) % bc == 0));
            if (tk[i]) ticks++;
            if (dn[i]) begin
                dones++;
                done_at = c;
            end
            if (noise) begin
                check("ready_low_busy", 32'(rdy[i]), 32'd0);
                if (c < len) drive(i, 1'($urandom % 2), 8'($urandom));
            end
            if (c < len) @(negedge clock);
        end
        drive(i, 1'b0, 8'h00);
        check("tick_count", 32'(ticks), 32'(nb));
        check("done_count", 32'(dones), 32'd1);
        check("done_cycle", 32'(done_at), 32'(len));
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        int dones;
        int d1;
        int d2;

        // reset state
        repeat (3) @(negedge clock);
        check("rst_ready", 32'(rdy), 32'd0);
        check("rst_tx", 32'(tx), 32'd0);
        check("rst_busy", 32'(bsy), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_rst", 32'(rdy), 32'd3);

        // 0xA5: preamble, start, 10100101, parity 0, stop
        run_frame(0, 8'hA5, 32'b1010101011010010100, 1'b0);
        // 0x01 with input noise during the frame: parity 1
        run_frame(0, 8'h01, 32'b1010101010000000110, 1'b1);
        // 0x00: data field and parity all zero
        run_frame(0, 8'h00, 32'b1010101010000000000, 1'b0);

        // back-to-back with data_valid held high
        wait_ready(0);
        drive(0, 1'b1, 8'h3C);
        ticks = 0;
        dones = 0;
        d1 = 0;
        d2 = 0;
        for (int c = 1; c <= 457; c++) begin
            @(negedge clock);
            if (c == 1) di0 = 8'hC3;
            if (c == 230) dv[0] = 1'b0;
            if (tk[0]) ticks++;
            if (dn[0]) begin
                dones++;
                if (d1 == 0) d1 = c;
                else d2 = c;
            end
            if (c == 229) begin
                check("gap_busy", 32'(bsy[0]), 32'd0);
                check("gap_ready", 32'(rdy[0]), 32'd1);
                check("gap_tx", 32'(tx[0]), 32'd0);
            end
        end
        check("b2b_ticks", 32'(ticks), 32'd38);
        check("b2b_dones", 32'(dones), 32'd2);
        check("b2b_done1", 32'(d1), 32'd228);
        check("b2b_done2", 32'(d2), 32'd457);
        @(negedge clock);

        // reset at cycle 100 of a frame
        wait_ready(0);
        drive(0, 1'b1, 8'h5A);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clock);
            if (c == 1) drive(0, 1'b0, 8'h00);
        end
        reset = 1'b1;
        @(negedge clock);
        check("abort_tx", 32'(tx[0]), 32'd0);
        check("abort_busy", 32'(bsy[0]), 32'd0);
        check("abort_done", 32'(dn[0]), 32'd0);
        reset = 1'b0;
        dones = 0;
        repeat (250) begin
            @(negedge clock);
            if (dn[0]) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_frame(0, 8'h5A, 32'b1010101010101101000, 1'b0);

        // reset wins over a simultaneous accept
        wait_ready(0);
        drive(0, 1'b1, 8'hFF);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        drive(0, 1'b0, 8'h00);
        check("rst_accept_busy", 32'(bsy[0]), 32'd0);
        repeat (5) @(negedge clock);
        check("rst_accept_idle", 32'(bsy[0]), 32'd0);
        check("rst_accept_ready", 32'(rdy[0]), 32'd1);

        // short configuration: 13 bits of 2 cycles = 26 cycles
        run_frame(1, 8'hB2, 32'b1011011001000, 1'b0);

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/optical_frame_tx.md
OPTICAL_FRAME_TX -- requirements
Module: optical_frame_tx

Interface
REQ-001 Parameter BIT_CYCLES, default 12, clock cycles per transmitted bit; matches the receiver sample clock period of 2*(5+1) cycles.
REQ-002 Parameter PREAMBLE_BITS, default 8, alternating-bit preamble length; even value, >= 2.
REQ-003 clock  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  8  payload byte; sampled only on accept.
REQ-006 data_valid  input  1  source has a byte available.
REQ-007 data_ready  output  1  block can accept a byte this cycle.
REQ-008 tx_out  output  1  optical line drive, LED on = 1; idle level 0.
REQ-009 busy  output  1  high from the cycle after accept through the last stop-bit cycle.
REQ-010 bit_tick  output  1  one-cycle pulse on the first cycle of every transmitted bit.
REQ-011 frame_done  output  1  one-cycle pulse on the final cycle of the stop bit.

Function
REQ-012 The FSM SHALL have states IDLE, PREAMBLE, START, DATA, PARITY, STOP.
REQ-013 Accept SHALL occur on a cycle where data_valid && data_ready; data_in SHALL be latched into a shift register on that edge.
REQ-014 data_ready SHALL be 1 only in IDLE and not in reset; it SHALL be a registered function of state, not of data_valid.
REQ-015 On accept the FSM SHALL enter PREAMBLE, and tx_out SHALL show the first preamble bit on the next cycle (latency 1 cycle).
REQ-016 Frame bit order SHALL be: PREAMBLE_BITS alternating bits starting with 1 (1,0,1,0,...), start bit 1, 8 data bits MSB first, even-parity bit (XOR of the 8 data bits), stop bit 0.
REQ-017 Each bit SHALL be held on tx_out for exactly BIT_CYCLES consecutive cycles, timed by a cycle counter of width ceil(log2(BIT_CYCLES)) that wraps from BIT_CYCLES-1 to 0.
REQ-018 A bit counter SHALL count bits within PREAMBLE (0..PREAMBLE_BITS-1) and DATA (0..7). It SHALL be cleared on each state transition.
REQ-019 State transitions SHALL occur only on the last cycle of a bit (cycle counter == BIT_CYCLES-1): PREAMBLE->START after the last preamble bit; START->DATA; DATA->PARITY after data bit 7; PARITY->STOP; STOP->IDLE.
REQ-020 A total frame SHALL occupy exactly (PREAMBLE_BITS+11)*BIT_CYCLES cycles; defaults give 228 cycles.
REQ-021 bit_tick SHALL pulse exactly PREAMBLE_BITS+11 times per frame, never in IDLE.
REQ-022 frame_done SHALL pulse exactly once per completed frame, coincident with the last STOP cycle.
REQ-023 Back-to-back: after STOP the FSM SHALL spend at least one cycle in IDLE (tx_out 0, data_ready 1) before a new accept, so the minimum frame-to-frame spacing is frame length + 1 cycle.
REQ-024 data_valid and data_in changes while busy SHALL be ignored. The latched byte SHALL NOT change mid-frame.
REQ-025 tx_out, busy, bit_tick and frame_done SHALL be registered outputs (glitch-free LED drive).

Reset
REQ-026 While reset is high: state = IDLE, counters = 0, shift register = 0, tx_out = 0, busy = 0, bit_tick = 0, frame_done = 0, data_ready = 0.
REQ-027 data_ready SHALL rise on the first cycle after reset deasserts.
REQ-028 Reset asserted mid-frame SHALL abort the frame on the next edge: tx_out = 0, no frame_done pulse, and the byte discarded.
REQ-029 Reset SHALL take priority over a simultaneous accept, and the byte SHALL NOT be transmitted.

Verification
REQ-030 Defaults, accept 0xA5 -> tx_out bit sequence 1,0,1,0,1,0,1,0, 1, 1,0,1,0,0,1,0,1, 0, 0, each bit 12 cycles; frame_done at cycle 228 after accept.
REQ-031 Accept 0x01 -> parity bit 1; accept 0x00 -> parity bit 0, data field all 0 for 96 cycles.
REQ-032 data_valid held high continuously with bytes 0x3C, 0xC3 -> two complete frames separated by exactly one IDLE cycle; 38 bit_tick pulses total.
REQ-033 Reset pulsed at cycle 100 of a frame -> tx_out 0 next cycle, busy 0, no frame_done; a subsequent 0x5A is transmitted correctly.
REQ-034 data_in toggled randomly and data_valid pulsed during a frame -> transmitted bits match the originally latched byte; data_ready stays 0 throughout.
REQ-035 BIT_CYCLES = 2, PREAMBLE_BITS = 2 -> frame length 26 cycles, and bit boundaries align with bit_tick.
